// File: rtl/rv32i_types_pkg.sv
// rv32i_types: types and constants shared by the RV32I pipeline stages.
//   fetch_state_t : fetch FSM states (FETCH, DRAIN, HOLD)
//   NOP_INSN      : canonical bubble instruction (addi x0,x0,0)
//   if_id_t       : IF/ID boundary record {valid, pc, ir}, also read by decode
//   pc_inc()      : sequential PC step, 32-bit modulo
package rv32i_types;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // read outstanding or about to be issued on req_addr
    DRAIN = 2'd1,  // stale read outstanding; its data will be thrown away
    HOLD  = 2'd2   // skid buffer full, no read issued
  } fetch_state_t;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] ir;
  } if_id_t;

  // Wraps naturally at 2^32 (0xFFFF_FFFC + 4 -> 0).
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage RV32I pipeline.
// Owns the fetch PC, runs the i-side read handshake, and fills the IF/ID
// boundary. A one-entry skid buffer absorbs a word that returns while decode
// is stalled; redirects that arrive mid-read wait for the stale read to
// complete (DRAIN) before the new target is requested.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   i_mem_rdata/i_mem_resp   instruction word and single-cycle completion
//   i_mem_address/i_mem_read fetch address and read request (held to resp)
//   i_mem_write/i_mem_wdata  tied to zero (fetch never writes)
//   stall                    decode not consuming; IF/ID holds
//   redirect_valid/_pc       control-flow change, beats stall everywhere
//   if_id_valid/_pc/_ir      IF/ID boundary contents
module fetch_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_resp,
  output logic [31:0] i_mem_address,
  output logic        i_mem_read,
  output logic        i_mem_write,
  output logic [31:0] i_mem_wdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_ir
);

  fetch_state_t state_q;
  logic [31:0]  req_addr_q;
  logic [31:0]  target_q;
  logic [31:0]  skid_pc_q;
  logic [31:0]  skid_ir_q;
  if_id_t       if_id_q;

  logic [31:0]  seq_pc_d;
  logic [31:0]  drain_dest_d;

  assign seq_pc_d     = pc_inc(req_addr_q);
  // A redirect arriving in the same cycle as the stale response is newer
  // than anything already captured in target_q.
  assign drain_dest_d = redirect_valid ? redirect_pc : target_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH;
      req_addr_q <= RESET_PC;
      target_q   <= '0;
      skid_pc_q  <= '0;
      skid_ir_q  <= '0;
      if_id_q    <= '{valid: 1'b0, pc: 32'd0, ir: NOP_INSN};
    end else begin
      // Default IF/ID behaviour: bubble when decode consumes or on any
      // redirect, otherwise hold. State cases below override with a real
      // instruction when one is available.
      if (redirect_valid || !stall) begin
        if_id_q.valid <= 1'b0;
        if_id_q.ir    <= NOP_INSN;
      end

      case (state_q)
        FETCH: begin
          if (i_mem_resp) begin
            if (redirect_valid) begin
              req_addr_q <= redirect_pc;
            end else begin
              req_addr_q <= seq_pc_d;
              if (stall) begin
                skid_pc_q <= req_addr_q;
                skid_ir_q <= i_mem_rdata;
                state_q   <= HOLD;
              end else begin
                if_id_q <= '{valid: 1'b1, pc: req_addr_q, ir: i_mem_rdata};
              end
            end
          end else if (redirect_valid) begin
            // Read in flight on the old path: it must complete unchanged.
            target_q <= redirect_pc;
            state_q  <= DRAIN;
          end
        end

        DRAIN: begin
          if (i_mem_resp) begin
            req_addr_q <= drain_dest_d;
            state_q    <= FETCH;
          end else if (redirect_valid) begin
            target_q <= redirect_pc;
          end
        end

        HOLD: begin
          if (redirect_valid) begin
            req_addr_q <= redirect_pc;
            state_q    <= FETCH;
          end else if (!stall) begin
            if_id_q <= '{valid: 1'b1, pc: skid_pc_q, ir: skid_ir_q};
            state_q <= FETCH;
          end
        end

        default: state_q <= FETCH;
      endcase
    end
  end

  // Gated by rst so the request drops immediately when reset is asserted.
  assign i_mem_read    = rst && (state_q != HOLD);
  assign i_mem_address = req_addr_q;
  assign i_mem_write   = 1'b0;
  assign i_mem_wdata   = '0;

  assign if_id_valid = if_id_q.valid;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_ir    = if_id_q.ir;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage.
// Stimulus pushes each instruction expected on IF/ID into sb_q; the monitor
// pops and compares every new IF/ID delivery. Inputs change on the falling
// edge; outputs are sampled 1 time unit after the rising edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        i_mem_resp = 1'b0;
  logic [31:0] i_mem_address;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [31:0] i_mem_wdata;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_ir;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .i_mem_rdata    (i_mem_rdata),
    .i_mem_resp     (i_mem_resp),
    .i_mem_address  (i_mem_address),
    .i_mem_read     (i_mem_read),
    .i_mem_write    (i_mem_write),
    .i_mem_wdata    (i_mem_wdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_ir       (if_id_ir)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   mem_lat  = 1;
  int   mem_cnt  = 0;
  logic mon_stall;
  logic [31:0] stab_addr;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endfunction

  // Memory contents: word at address a is (a << 12) | 0x93.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 12) | 32'h0000_0093;
  endfunction

  task automatic push(input logic [31:0] pc, input logic [31:0] ir);
    exp_t e;
    e.pc = pc;
    e.ir = ir;
    sb_q.push_back(e);
  endtask

  // Caller must be at a falling edge.
  task automatic hold_reset();
    rst = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    sb_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset(input int lat);
    mem_lat = lat;
    rst = 1'b1;
  endtask

  task automatic drain_sb(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
    chk("sb_drain_left", sb_q.size(), 32'd0);
  endtask

  // Memory model: response after mem_lat cycles of i_mem_read.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst && i_mem_read) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          i_mem_resp  = 1'b1;
          i_mem_rdata = mem_word(i_mem_address);
          mem_cnt     = 0;
        end else begin
          i_mem_resp  = 1'b0;
          i_mem_rdata = 32'hDEAD_BEEF;
        end
      end else begin
        i_mem_resp = 1'b0;
        mem_cnt    = 0;
      end
    end
  end

  // Scoreboard monitor: a new delivery is valid IF/ID after an edge with stall=0.
  initial begin
    forever begin
      @(posedge clk);
      mon_stall = stall;
      #1;
      if (rst && !mon_stall && if_id_valid) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: got pc %h ir %h, required no delivery",
                   if_id_pc, if_id_ir);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_pc", if_id_pc, e.pc);
          chk("sb_ir", if_id_ir, e.ir);
        end
      end
    end
  end

  // A pending read must keep its address until the response.
  initial begin
    forever begin
      @(posedge clk);
      if (rst && i_mem_read && !i_mem_resp) begin
        stab_addr = i_mem_address;
        #1;
        if (rst) chk("addr_stable", i_mem_address, stab_addr);
      end
    end
  end

  initial begin
    // ---- Test 1: reset values and back-to-back fetch ----
    hold_reset();
    #1;
    chk("rst_read", {31'd0, i_mem_read}, 32'd0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_pc", if_id_pc, 32'd0);
    chk("rst_ir", if_id_ir, 32'h0000_0013);
    chk("rst_addr", i_mem_address, 32'h0000_0060);
    chk("rst_write", {31'd0, i_mem_write}, 32'd0);
    chk("rst_wdata", i_mem_wdata, 32'd0);
    @(negedge clk);
    release_reset(1);
    push(32'h60, 32'h0006_0093);
    push(32'h64, 32'h0006_4093);
    push(32'h68, 32'h0006_8093);
    push(32'h6C, 32'h0006_C093);
    @(posedge clk); #1;
    chk("t1_addr0", i_mem_address, 32'h64);
    chk("t1_valid0", {31'd0, if_id_valid}, 32'd1);
    @(posedge clk); #1;
    chk("t1_addr1", i_mem_address, 32'h68);
    chk("t1_pc1", if_id_pc, 32'h64);
    @(posedge clk); #1;
    chk("t1_addr2", i_mem_address, 32'h6C);
    chk("t1_pc2", if_id_pc, 32'h68);
    drain_sb(10);

    // ---- Test 2: stall while response arrives -> HOLD ----
    hold_reset();
    release_reset(1);
    push(32'h60, 32'h0006_0093);
    push(32'h64, 32'h0006_4093);
    push(32'h68, 32'h0006_8093);
    @(posedge clk); #1;
    chk("t2_pc0", if_id_pc, 32'h60);
    @(negedge clk);
    stall = 1'b1;
    @(posedge clk); #1;
    chk("t2_hold_read", {31'd0, i_mem_read}, 32'd0);
    chk("t2_hold_addr", i_mem_address, 32'h68);
    chk("t2_hold_pc", if_id_pc, 32'h60);
    @(posedge clk); #1;
    chk("t2_hold2_read", {31'd0, i_mem_read}, 32'd0);
    chk("t2_hold2_pc", if_id_pc, 32'h60);
    @(posedge clk); #1;
    chk("t2_hold3_valid", {31'd0, if_id_valid}, 32'd1);
    chk("t2_hold3_pc", if_id_pc, 32'h60);
    @(negedge clk);
    stall = 1'b0;
    @(posedge clk); #1;
    chk("t2_rel_pc", if_id_pc, 32'h64);
    chk("t2_rel_read", {31'd0, i_mem_read}, 32'd1);
    chk("t2_rel_addr", i_mem_address, 32'h68);
    drain_sb(10);

    // ---- Test 3: redirect during a 4-cycle read -> DRAIN ----
    hold_reset();
    release_reset(4);
    push(32'h60, 32'h0006_0093);
    push(32'h64, 32'h0006_4093);
    push(32'h200, 32'h0020_0093);
    repeat (9) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(posedge clk); #1;
    chk("t3_drain_addr", i_mem_address, 32'h68);
    chk("t3_drain_read", {31'd0, i_mem_read}, 32'd1);
    chk("t3_drain_valid", {31'd0, if_id_valid}, 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    @(posedge clk); #1;
    chk("t3_drain2_addr", i_mem_address, 32'h68);
    @(posedge clk); #1;
    chk("t3_new_addr", i_mem_address, 32'h200);
    chk("t3_new_valid", {31'd0, if_id_valid}, 32'd0);
    drain_sb(20);

    // ---- Test 4: two redirects in one DRAIN, latest wins ----
    hold_reset();
    release_reset(4);
    push(32'h60, 32'h0006_0093);
    push(32'h300, 32'h0030_0093);
    repeat (4) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(posedge clk); #1;
    chk("t4_addr_kept", i_mem_address, 32'h64);
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(posedge clk); #1;
    chk("t4_new_addr", i_mem_address, 32'h300);
    chk("t4_valid", {31'd0, if_id_valid}, 32'd0);
    drain_sb(20);

    // ---- Test 5: resp + redirect + stall in one cycle ----
    hold_reset();
    release_reset(1);
    push(32'h60, 32'h0006_0093);
    push(32'h400, 32'h0040_0093);
    @(negedge clk);
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h400;
    @(posedge clk); #1;
    chk("t5_valid", {31'd0, if_id_valid}, 32'd0);
    chk("t5_ir", if_id_ir, 32'h0000_0013);
    chk("t5_addr", i_mem_address, 32'h400);
    @(negedge clk);
    stall = 1'b0;
    redirect_valid = 1'b0;
    drain_sb(10);

    // ---- Test 6: reset asserted mid-read at 0x80 ----
    hold_reset();
    release_reset(1);
    for (int i = 0; i < 8; i++) push(32'h60 + 32'(4 * i), mem_word(32'h60 + 32'(4 * i)));
    repeat (8) @(negedge clk);
    mem_lat = 100;
    @(negedge clk);
    chk("t6_pre_addr", i_mem_address, 32'h80);
    chk("t6_pre_read", {31'd0, i_mem_read}, 32'd1);
    chk("t6_sb_empty", sb_q.size(), 32'd0);
    rst = 1'b0;
    #1;
    chk("t6_rst_read", {31'd0, i_mem_read}, 32'd0);
    chk("t6_rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("t6_rst_addr", i_mem_address, 32'h60);
    @(negedge clk);
    release_reset(1);
    push(32'h60, 32'h0006_0093);
    #1;
    chk("t6_first_addr", i_mem_address, 32'h60);
    drain_sb(5);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage RV32I pipeline.
- Owns the fetch PC and runs the i-side memory handshake.
- Delivers {valid, pc, ir} into the IF/ID boundary consumed by decode.
- Handles hazard-unit stalls with a one-entry skid buffer, and branch/jump redirects including discard of an in-flight read.

Parameters:
RESET_PC, 32'h0000_0060, first fetch address after reset
NOP_INSN, 32'h0000_0013, IR value presented when if_id_valid=0 (addi x0,x0,0)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
i_mem_rdata  input  32  instruction word, valid when i_mem_resp=1
i_mem_resp  input  1  read completion, single-cycle pulse
i_mem_address  output  32  fetch address (= req_addr register)
i_mem_read  output  1  read request, held until i_mem_resp
i_mem_write  output  1  constant 0
i_mem_wdata  output  32  constant 0
stall  input  1  hold IF/ID contents (decode not consuming)
redirect_valid  input  1  control-flow change from EX/MEM
redirect_pc  input  32  target PC, valid with redirect_valid
if_id_valid  output  1  IF/ID slot holds a real instruction
if_id_pc  output  32  PC of if_id_ir
if_id_ir  output  32  fetched instruction

Behaviour:
- Reset (rst=0, async):
  - state=FETCH, req_addr=RESET_PC.
  - if_id_valid=0, if_id_pc=0, if_id_ir=NOP_INSN.
  - Skid buffer cleared, target=0.
  - i_mem_read=0 while rst=0.
- Outputs:
  - i_mem_read combinational: 1 in FETCH and DRAIN, 0 in HOLD.
  - i_mem_address is always req_addr, stable while a read is pending.
  - A pending read is never dropped or changed before i_mem_resp.
- IF/ID update rule:
  - When stall=0, IF/ID loads the new instruction if one is available this cycle; otherwise it loads a bubble (valid=0, ir=NOP_INSN).
  - When stall=1, IF/ID holds.
  - redirect_valid=1 forces a bubble into IF/ID, overriding stall.
- FETCH:
  - resp & !redirect & !stall: IF/ID <= {1, req_addr, rdata}; req_addr += 4; stay in FETCH.
  - resp & !redirect & stall: buffer <= {req_addr, rdata}; req_addr += 4; go to HOLD.
  - resp & redirect: rdata discarded; req_addr <= redirect_pc; stay in FETCH.
  - !resp & redirect: target <= redirect_pc; go to DRAIN.
  - !resp & !redirect: stay in FETCH.
- DRAIN (a stale read is outstanding):
  - Read stays asserted on the old req_addr.
  - A further redirect overwrites target; the latest redirect wins.
  - On resp: data discarded; req_addr <= target (or redirect_pc if redirect is asserted this cycle); go to FETCH.
- HOLD (buffer full, no request issued):
  - redirect: buffer discarded; req_addr <= redirect_pc; go to FETCH.
  - else if !stall: IF/ID <= {1, buffer}; go to FETCH.
  - else stay in HOLD.
- Throughput and latency:
  - With a same-cycle-resp memory: one instruction per cycle.
  - Instruction appears on IF/ID the cycle after resp.
  - First IF/ID valid is 1 cycle after the first resp following reset release.
- Arithmetic: PC increment is 32-bit modulo, so 0xFFFF_FFFC+4 wraps to 0. Redirect targets are used unchecked; alignment is decode/EX responsibility.
- Simultaneous events:
  - redirect beats stall in every state.
  - resp+redirect in the same cycle never delivers the fetched word.
- Reset mid-read: abandons the read; memory must tolerate i_mem_read dropping on reset.

Decomposition:
- Shared package rv32i_types gets:
  - fetch_state_t enum {FETCH, DRAIN, HOLD};
  - NOP_INSN constant;
  - if_id_t packed struct {valid, pc, ir} for the IF/ID boundary, reused by decode.
- Skid buffer and IF/ID flops are inline; no sub-module is required.

Test Plan:
- Reset release, memory resp same cycle, rdata = 0x00000013, 0x00100093, ... → i_mem_address 0x60, 0x64, 0x68 on consecutive cycles; if_id_pc lags by 1 cycle with valid=1 each cycle.
- Resp for 0x64 while stall=1, stall held 3 cycles → state HOLD, i_mem_read=0, IF/ID keeps 0x60. When stall drops, IF/ID={1,0x64,…} and the next request is 0x68.
- Memory latency 4 cycles, redirect to 0x200 at cycle 2 of the read of 0x68 → address stays 0x68 until resp. That rdata never appears on IF/ID. Next request is 0x200; IF/ID valid=0 in between.
- Redirect to 0x100, then to 0x300, during the same DRAIN → next fetch is 0x300.
- resp, redirect=0x400 and stall=1 in the same cycle → IF/ID valid=0 next cycle and the next address is 0x400.
- Assert rst low mid-read at address 0x80 → immediately i_mem_read=0 and if_id_valid=0. After release, the first address is 0x60.
